// File: rtl/mux4_rr_feeder.sv
// mux4_rr_feeder: buffers one word per channel from four valid/ready inputs and
// presents them to a 4-to-1 mux with a registered round-robin select.
//   clk, rst_n         : clock, asynchronous active-low reset
//   in_valid/in_ready  : per-channel input handshake (in_ready = ~full)
//   in_data0..3        : channel input words
//   d0..d3             : channel holding registers, wired to the mux data inputs
//   sel                : registered mux select
//   out_valid/out_ready: handshake for the word at d[sel]
module mux4_rr_feeder #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   in_valid,
    input  logic [W-1:0] in_data0,
    input  logic [W-1:0] in_data1,
    input  logic [W-1:0] in_data2,
    input  logic [W-1:0] in_data3,
    output logic [3:0]   in_ready,
    output logic [W-1:0] d0,
    output logic [W-1:0] d1,
    output logic [W-1:0] d2,
    output logic [W-1:0] d3,
    output logic [1:0]   sel,
    output logic         out_valid,
    input  logic         out_ready
);
    typedef enum logic {IDLE, PRESENT} state_t;

    state_t       state_q;
    logic [3:0]   full_q, full_d, in_fire, clr, cand;
    logic [W-1:0] data_q [4];
    logic [W-1:0] in_data [4];
    logic [1:0]   sel_q, last_q, base, pick;
    logic         out_fire;

    assign in_data[0] = in_data0;
    assign in_data[1] = in_data1;
    assign in_data[2] = in_data2;
    assign in_data[3] = in_data3;
    assign d0 = data_q[0];
    assign d1 = data_q[1];
    assign d2 = data_q[2];
    assign d3 = data_q[3];
    assign sel = sel_q;
    assign out_valid = state_q == PRESENT;
    assign in_ready = ~full_q;
    assign in_fire = in_valid & ~full_q;
    assign out_fire = out_valid & out_ready;
    // the word being consumed is freed and is no longer a candidate this cycle
    assign clr = out_fire ? 4'b0001 << sel_q : 4'b0000;
    assign cand = full_q & ~clr;
    assign full_d = cand | in_fire;
    // rotate from the channel just served, otherwise from the last grant
    assign base = out_fire ? sel_q : last_q;

    // walk the offsets from farthest to nearest so the nearest candidate wins
    always_comb begin
        pick = base;
        for (int k = 4; k >= 1; k--) begin
            pick = cand[base + 2'(k)] ? base + 2'(k) : pick;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            full_q  <= 4'b0000;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;
            for (int n = 0; n < 4; n++) data_q[n] <= '0;
        end else begin
            full_q <= full_d;
            for (int n = 0; n < 4; n++) if (in_fire[n]) data_q[n] <= in_data[n];
            if (out_fire) last_q <= sel_q;
            if (state_q == IDLE || out_fire) begin
                state_q <= |cand ? PRESENT : IDLE;
                if (|cand) sel_q <= pick;
            end
        end
    end
endmodule

// File: tb/tb_mux4_rr_feeder.sv
// tb_mux4_rr_feeder: directed vector table plus hand-written reset sequences.
module tb_mux4_rr_feeder;
    typedef struct packed {
        logic       rst_n;
        logic [3:0] iv;
        logic [7:0] idata;
        logic       ordy;
        logic [3:0] e_irdy;
        logic       e_ov;
        logic [1:0] e_sel;
        logic [7:0] e_d;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in_valid;
    logic [1:0] in_data0, in_data1, in_data2, in_data3;
    logic [3:0] in_ready;
    logic [1:0] d0, d1, d2, d3;
    logic [1:0] sel;
    logic       out_valid;
    logic       out_ready;
    int         n_vec = 0;
    int         n_bad = 0;
    vec_t       tbl [30];

    mux4_rr_feeder #(.W(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
        .in_ready(in_ready), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .sel(sel), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] irdy, input logic ov,
                         input logic [1:0] s, input logic [7:0] d);
        n_vec++;
        if (in_ready !== irdy) begin
            n_bad++;
            $display("FAIL %s in_ready got %b want %b", name, in_ready, irdy);
        end
        if (out_valid !== ov) begin
            n_bad++;
            $display("FAIL %s out_valid got %b want %b", name, out_valid, ov);
        end
        if (sel !== s) begin
            n_bad++;
            $display("FAIL %s sel got %0d want %0d", name, sel, s);
        end
        if ({d3, d2, d1, d0} !== d) begin
            n_bad++;
            $display("FAIL %s d3..d0 got %h want %h", name, {d3, d2, d1, d0}, d);
        end
    endtask

    task automatic apply(input int i);
        rst_n = tbl[i].rst_n;
        in_valid = tbl[i].iv;
        {in_data3, in_data2, in_data1, in_data0} = tbl[i].idata;
        out_ready = tbl[i].ordy;
        @(posedge clk);
        #1;
        check($sformatf("vec%0d", i + 1), tbl[i].e_irdy, tbl[i].e_ov, tbl[i].e_sel, tbl[i].e_d);
    endtask

    initial begin
        // single word on channel 2
        tbl[0]  = '{1'b1, 4'b0100, 8'h20, 1'b1, 4'b1011, 1'b0, 2'd0, 8'h20};
        tbl[1]  = '{1'b1, 4'b0000, 8'h00, 1'b1, 4'b1011, 1'b1, 2'd2, 8'h20};
        tbl[2]  = '{1'b1, 4'b0000, 8'h00, 1'b1, 4'b1111, 1'b0, 2'd2, 8'h20};
        // reset, then all four loaded at once: grants 0,1,2,3 back-to-back
        tbl[3]  = '{1'b0, 4'b0000, 8'h00, 1'b0, 4'b1111, 1'b0, 2'd0, 8'h00};
        tbl[4]  = '{1'b1, 4'b1111, 8'hE4, 1'b1, 4'b0000, 1'b0, 2'd0, 8'hE4};
        tbl[5]  = '{1'b1, 4'b0000, 8'h00, 1'b1, 4'b0000, 1'b1, 2'd0, 8'hE4};
        tbl[6]  = '{1'b1, 4'b0000, 8'h00, 1'b1, 4'b0001, 1'b1, 2'd1, 8'hE4};
        tbl[7]  = '{1'b1, 4'b0000, 8'h00, 1'b1, 4'b0011, 1'b1, 2'd2, 8'hE4};
        tbl[8]  = '{1'b1, 4'b0000, 8'h00, 1'b1, 4'b0111, 1'b1, 2'd3, 8'hE4};
        tbl[9]  = '{1'b1, 4'b0000, 8'h00, 1'b1, 4'b1111, 1'b0, 2'd3, 8'hE4};
        // backpressure on channel 1; new data offered while full must be ignored
        tbl[10] = '{1'b1, 4'b0010, 8'h0C, 1'b0, 4'b1101, 1'b0, 2'd3, 8'hEC};
        tbl[11] = '{1'b1, 4'b0010, 8'h04, 1'b0, 4'b1101, 1'b1, 2'd1, 8'hEC};
        for (int i = 12; i < 17; i++)
            tbl[i] = '{1'b1, 4'b0010, 8'h04, 1'b0, 4'b1101, 1'b1, 2'd1, 8'hEC};
        tbl[17] = '{1'b1, 4'b0000, 8'h00, 1'b1, 4'b1111, 1'b0, 2'd1, 8'hEC};
        // grant 2, then channels 0 and 3 together: 3 before 0
        tbl[18] = '{1'b1, 4'b0100, 8'h10, 1'b1, 4'b1011, 1'b0, 2'd1, 8'hDC};
        tbl[19] = '{1'b1, 4'b1001, 8'h02, 1'b1, 4'b0010, 1'b1, 2'd2, 8'h1E};
        tbl[20] = '{1'b1, 4'b0000, 8'h00, 1'b1, 4'b0110, 1'b1, 2'd3, 8'h1E};
        tbl[21] = '{1'b1, 4'b0010, 8'h04, 1'b1, 4'b1100, 1'b1, 2'd0, 8'h16};
        // refill of channel 0 while it fires: refused, captured next cycle, served last
        tbl[22] = '{1'b1, 4'b0001, 8'h03, 1'b1, 4'b1101, 1'b1, 2'd1, 8'h16};
        tbl[23] = '{1'b1, 4'b0101, 8'h23, 1'b0, 4'b1000, 1'b1, 2'd1, 8'h27};
        tbl[24] = '{1'b1, 4'b0000, 8'h00, 1'b1, 4'b1010, 1'b1, 2'd2, 8'h27};
        tbl[25] = '{1'b1, 4'b0000, 8'h00, 1'b1, 4'b1110, 1'b1, 2'd0, 8'h27};
        // build full = 1011 with out_valid high for the mid-operation reset
        tbl[26] = '{1'b1, 4'b1010, 8'h40, 1'b0, 4'b0100, 1'b1, 2'd0, 8'h63};
        // after reset the lowest-numbered full channel is granted first
        tbl[27] = '{1'b0, 4'b0000, 8'h00, 1'b0, 4'b1111, 1'b0, 2'd0, 8'h00};
        tbl[28] = '{1'b1, 4'b1100, 8'h90, 1'b0, 4'b0011, 1'b0, 2'd0, 8'h90};
        tbl[29] = '{1'b1, 4'b0000, 8'h00, 1'b0, 4'b0011, 1'b1, 2'd2, 8'h90};

        rst_n = 1'b0;
        in_valid = 4'b0000;
        {in_data3, in_data2, in_data1, in_data0} = 8'h00;
        out_ready = 1'b0;
        #1;
        check("reset", 4'b1111, 1'b0, 2'd0, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 27; i++) apply(i);

        // asynchronous reset between edges must clear everything at once
        rst_n = 1'b0;
        #1;
        check("async_reset", 4'b1111, 1'b0, 2'd0, 8'h00);

        for (int i = 27; i < 30; i++) apply(i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
